// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, error causes,
// FSM state encoding and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W);
        if (!we) begin
            ok = ok || (f3 == LSU_BU) || (f3 == LSU_HU);
        end
        return !ok;
    endfunction

    // f3[1:0] encodes the access size for every legal code (byte, half, word).
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering shared by the store and load paths: byte enables,
// store-data replication and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  be_base;
    logic [31:0] rdata_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sign_ext;

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign be_o = be_base << addr_lo_i;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (funct3_i[1:0])
                    2'b00:   wdata_o[gi*8 +: 8] = wdata_i[7:0];
                    2'b01:   wdata_o[gi*8 +: 8] = wdata_i[(gi % 2)*8 +: 8];
                    default: wdata_o[gi*8 +: 8] = wdata_i[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    // Bring the addressed byte/half down to lane 0, then extend.
    assign rdata_shift = rdata_i >> {addr_lo_i, 3'b000};
    assign rd_byte     = rdata_shift[7:0];
    assign rd_half     = rdata_shift[15:0];
    assign sign_ext    = !funct3_i[2];

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   rdata_o = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            2'b01:   rdata_o = {{16{sign_ext & rd_half[15]}}, rd_half};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request over a
// req/gnt/rvalid bus, with misaligned, illegal-funct3 and timeout errors.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_rdata_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [4:0]       rd_q;

    logic             accept;
    logic             timed_out;
    logic [3:0]       be_w;
    logic [31:0]      wdata_w;
    logic [31:0]      rdata_w;

    assign accept    = req_valid_i && (state_q == ST_IDLE);
    // Last allowed REQ/WAIT cycle; a gnt/rvalid in that same cycle still wins.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    lsu_align u_align (
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata_i),
        .be_o      (be_w),
        .wdata_o   (wdata_w),
        .rdata_o   (rdata_w)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid_i) begin
                    if (funct3_illegal(req_we_i, req_funct3_i)) begin
                        state_d = ST_ERR;
                        cause_d = ERR_ILLEGAL;
                    end else if (addr_misaligned(req_funct3_i, req_addr_i[1:0])) begin
                        state_d = ST_ERR;
                        cause_d = ERR_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                    cnt_d   = we_q ? '0 : cnt_q + CNT_W'(1);
                end else if (timed_out) begin
                    state_d = ST_ERR;
                    cause_d = ERR_TIMEOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_DONE;
                    rdata_d = rdata_w;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                    cause_d = ERR_TIMEOUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cause_q <= ERR_NONE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
        end
    end

    // Outputs decode straight from state so an async reset zeroes them at once.
    assign req_ready_o = (state_q == ST_IDLE);
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be_o    = mem_req_o ? be_w : 4'd0;
    assign mem_wdata_o = mem_we_o ? wdata_w : 32'd0;
    assign rsp_valid_o = (state_q == ST_DONE);
    assign rsp_rd_o    = (rsp_valid_o && !we_q) ? rd_q : 5'd0;
    assign rsp_rdata_o = (rsp_valid_o && !we_q) ? rdata_q : 32'd0;
    assign err_o       = (state_q == ST_ERR);
    assign err_cause_o = cause_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a per-cycle expectation map built from the
// access rules, one compare process, plus literal checks from the test plan.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        req_ready, mem_req, mem_we, rsp_valid, err;
    logic [31:0] mem_addr, mem_wdata, rsp_rdata;
    logic [3:0]  mem_be;
    logic [4:0]  rsp_rd;
    logic [1:0]  err_cause;

    logic        t_valid, t_gnt, t_rvalid;
    logic        t_ready, t_mreq, t_mwe, t_rspv, t_err;
    logic [31:0] t_maddr, t_mwd, t_rsprdata;
    logic [3:0]  t_mbe;
    logic [4:0]  t_rsprd;
    logic [1:0]  t_cause;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;
    logic [1:0] m_cause = 2'b00;

    int mreq_cnt = 0, rsp_cnt = 0, rsp_cyc = -1, err_cyc = -1;
    logic [31:0] cap_addr, cap_wd, cap_rdata;
    logic [3:0]  cap_be;
    logic [4:0]  cap_rd;
    logic [1:0]  cap_cause;

    typedef struct {
        logic        ready, mreq, we, rv, err;
        logic [31:0] addr, wd, rdata;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic [1:0]  cause;
    } exp_t;
    exp_t exp_map [int];

    lsu dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .rsp_valid_o(rsp_valid),
        .rsp_rd_o(rsp_rd), .rsp_rdata_o(rsp_rdata), .err_o(err), .err_cause_o(err_cause)
    );

    lsu #(.TIMEOUT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(t_valid), .req_ready_o(t_ready),
        .req_we_i(1'b0), .req_funct3_i(3'b010), .req_addr_i(32'h0000_0500),
        .req_wdata_i(32'd0), .req_rd_i(5'd9), .mem_req_o(t_mreq), .mem_gnt_i(t_gnt),
        .mem_we_o(t_mwe), .mem_addr_o(t_maddr), .mem_be_o(t_mbe), .mem_wdata_o(t_mwd),
        .mem_rvalid_i(t_rvalid), .mem_rdata_i(32'h1111_2222), .rsp_valid_o(t_rspv),
        .rsp_rd_o(t_rsprd), .rsp_rdata_o(t_rsprdata), .err_o(t_err), .err_cause_o(t_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, expv);
        end
    endtask

    function automatic exp_t idle_rec(input logic [1:0] cause);
        exp_t e;
        e.ready = 1'b1; e.mreq = 1'b0; e.we = 1'b0; e.rv = 1'b0; e.err = 1'b0;
        e.addr = 32'd0; e.wd = 32'd0; e.rdata = 32'd0; e.be = 4'd0; e.rd = 5'd0;
        e.cause = cause;
        return e;
    endfunction

    // Reference rules: access size n bytes = 2**f3[1:0].
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] v;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        v  = word >> (8 * a[1:0]);
        sb = v[7:0];
        sh = v[15:0];
        case (f3)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh);
            3'b100:  return 32'(v[7:0]);
            3'b101:  return 32'(v[15:0]);
            default: return word;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = exp_map.exists(cyc) ? exp_map[cyc] : idle_rec(m_cause);
            chk("req_ready", req_ready, e.ready);
            chk("mem_req", mem_req, e.mreq);
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_be", mem_be, e.be);
            chk("mem_wdata", mem_wdata, e.wd);
            chk("rsp_valid", rsp_valid, e.rv);
            chk("rsp_rd", rsp_rd, e.rd);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("err", err, e.err);
            chk("err_cause", err_cause, e.cause);
            if (mem_req) begin
                mreq_cnt++; cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_cyc = cyc; cap_rd = rsp_rd; cap_rdata = rsp_rdata;
            end
            if (err) begin
                err_cyc = cyc; cap_cause = err_cause;
            end
        end
    end

    // Call just after a rising edge with the DUT idle; returns the accept cycle.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int g, input int r,
                        input logic [31:0] word, input bit gnt_rv, input bit noise, output int c);
        exp_t e;
        logic bad;
        logic [1:0] cause;
        int n, d;
        c = cyc;
        n = 1 << f3[1:0];
        bad = 1'b1;
        cause = 2'b10;
        if (we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            if ((int'(addr[1:0]) % n) != 0) cause = 2'b01;
            else bad = 1'b0;
        end
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
        if (bad) begin
            e = idle_rec(cause); e.ready = 0; e.err = 1;
            exp_map[c+1] = e;
            @(posedge clk); #1; req_valid = 0;
            @(posedge clk); #1; m_cause = cause;
            return;
        end
        d = we ? c + 2 + g : c + 3 + g + r;
        for (int k = c + 1; k <= c + 1 + g; k++) begin
            e = idle_rec(m_cause); e.ready = 0; e.mreq = 1; e.we = we;
            e.addr = {addr[31:2], 2'b00}; e.be = m_be(f3, addr);
            e.wd = we ? m_wd(f3, wd) : 32'd0;
            exp_map[k] = e;
        end
        for (int k = c + 2 + g; k < d; k++) begin
            e = idle_rec(m_cause); e.ready = 0;
            exp_map[k] = e;
        end
        e = idle_rec(m_cause); e.ready = 0; e.rv = 1;
        e.rd = we ? 5'd0 : rd;
        e.rdata = we ? 32'd0 : m_load(f3, addr, word);
        exp_map[d] = e;

        @(posedge clk); #1;
        if (noise) begin
            req_funct3 = 3'b111; req_addr = 32'h3; req_we = 1;
        end else begin
            req_valid = 0;
        end
        for (int i = 0; i < g; i++) begin
            mem_gnt = 0; @(posedge clk); #1;
        end
        mem_gnt = 1; mem_rvalid = gnt_rv; mem_rdata = gnt_rv ? 32'hBAD0_BAD0 : 32'd0;
        @(posedge clk); #1;
        mem_gnt = 0; mem_rvalid = 0;
        if (!we) begin
            for (int i = 0; i < r; i++) begin
                @(posedge clk); #1;
            end
            mem_rvalid = 1; mem_rdata = word;
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = 32'd0;
        end
        req_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int c, m0, r0;
        exp_t e;
        rst_ni = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; req_rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        t_valid = 0; t_gnt = 0; t_rvalid = 0;
        #3;
        chk("rst_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_cause", err_cause, 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1; cmp_en = 1;
        @(posedge clk); #1;

        xact(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd5, 0, 0, 0, 0, 0, c);
        chk("sw_addr", cap_addr, 32'h100);
        chk("sw_be", cap_be, 4'b1111);
        chk("sw_wdata", cap_wd, 32'hDEADBEEF);
        chk("sw_latency", rsp_cyc - c, 2);
        chk("sw_rd", cap_rd, 0);

        xact(1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 0, 0, 0, 0, 0, c);
        chk("sb_be", cap_be, 4'b1000);
        chk("sb_wdata", cap_wd, 32'hA5A5A5A5);
        chk("sb_addr", cap_addr, 32'h100);

        xact(0, 3'b000, 32'h202, 32'd0, 5'd3, 0, 0, 32'h1280FF34, 0, 0, c);
        chk("lb_rdata", cap_rdata, 32'hFFFFFF80);
        chk("lb_rd", cap_rd, 3);
        chk("lb_latency", rsp_cyc - c, 3);
        xact(0, 3'b100, 32'h202, 32'd0, 5'd4, 0, 0, 32'h1280FF34, 0, 0, c);
        chk("lbu_rdata", cap_rdata, 32'h00000080);
        xact(0, 3'b101, 32'h202, 32'd0, 5'd6, 0, 0, 32'h1280FF34, 0, 0, c);
        chk("lhu_rdata", cap_rdata, 32'h00001280);
        xact(0, 3'b001, 32'h200, 32'd0, 5'd8, 0, 0, 32'h12348001, 0, 0, c);
        chk("lh_rdata", cap_rdata, 32'hFFFF8001);
        xact(1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 0, 0, 0, 0, 0, c);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wd, 32'hABCDABCD);

        m0 = mreq_cnt;
        xact(0, 3'b010, 32'h101, 32'd0, 5'd2, 0, 0, 0, 0, 0, c);
        chk("lw_mis_cause", cap_cause, 2'b01);
        chk("lw_mis_latency", err_cyc - c, 1);
        xact(0, 3'b110, 32'h200, 32'd0, 5'd2, 0, 0, 0, 0, 0, c);
        chk("ld110_cause", cap_cause, 2'b10);
        xact(1, 3'b100, 32'h003, 32'd0, 5'd0, 0, 0, 0, 0, 0, c);
        chk("illegal_over_mis", cap_cause, 2'b10);
        xact(0, 3'b001, 32'h201, 32'd0, 5'd2, 0, 0, 0, 0, 0, c);
        xact(0, 3'b101, 32'h203, 32'd0, 5'd2, 0, 0, 0, 0, 0, c);
        xact(1, 3'b010, 32'h102, 32'd0, 5'd0, 0, 0, 0, 0, 0, c);
        chk("sw_mis_cause", cap_cause, 2'b01);
        chk("err_no_mem_req", mreq_cnt - m0, 0);

        m0 = mreq_cnt; r0 = rsp_cnt;
        xact(0, 3'b010, 32'h400, 32'd0, 5'd31, 3, 2, 32'hCAFEF00D, 1, 1, c);
        chk("slow_mreq_cycles", mreq_cnt - m0, 4);
        chk("slow_rsp_count", rsp_cnt - r0, 1);
        chk("slow_rdata", cap_rdata, 32'hCAFEF00D);
        chk("slow_latency", rsp_cyc - c, 8);

        // Asynchronous reset while waiting for read data.
        c = cyc; r0 = rsp_cnt;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300; req_rd = 5'd7;
        e = idle_rec(m_cause); e.ready = 0; e.mreq = 1; e.addr = 32'h300; e.be = 4'hF;
        exp_map[c+1] = e;
        @(posedge clk); #1; req_valid = 0; mem_gnt = 1;
        @(posedge clk); #1; mem_gnt = 0;
        rst_ni = 0; m_cause = 2'b00; #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_mem_req", mem_req, 0);
        chk("arst_rsp", rsp_valid, 0);
        chk("arst_cause", err_cause, 0);
        @(posedge clk); #1; rst_ni = 1;
        @(posedge clk); #1; mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(posedge clk); #1; mem_rvalid = 0;
        @(posedge clk); #1;
        chk("stray_rvalid_rsp", rsp_cnt - r0, 0);

        xact(1, 3'b010, 32'h104, 32'h0BADF00D, 5'd0, 1, 0, 0, 0, 0, c);
        chk("post_rst_sw_latency", rsp_cyc - c, 3);

        // TIMEOUT=4 instance: no grant ever arrives.
        t_valid = 1;
        @(posedge clk); #1; t_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_mem_req", t_mreq, 1);
            chk("to_mem_addr", t_maddr, 32'h500);
            chk("to_ready", t_ready, 0);
        end
        @(negedge clk);
        chk("to_err", t_err, 1);
        chk("to_cause", t_cause, 2'b11);
        chk("to_req_drop", t_mreq, 0);
        @(negedge clk);
        chk("to_ready_after", t_ready, 1);
        chk("to_err_pulse", t_err, 0);
        chk("to_cause_held", t_cause, 2'b11);
        @(posedge clk); #1; t_gnt = 1; t_rvalid = 1;
        @(negedge clk);
        chk("late_rsp", t_rspv, 0);
        chk("late_mreq", t_mreq, 0);
        @(posedge clk); #1; t_gnt = 0; t_rvalid = 0;
        @(negedge clk);
        chk("late_rsp2", t_rspv, 0);
        chk("late_ready", t_ready, 1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name:
lsu

Overview:
Load/store unit directly downstream of the ALU in the execute stage. It takes the ALU result as the effective address plus rs2 store data, and runs one data-memory transaction over a req/gnt/rvalid bus. Loads return byte-lane-aligned, sign- or zero-extended data tagged with rd. Misaligned accesses, unsupported funct3 codes and bus timeouts are flagged as errors.

Parameters:
TIMEOUT, 256, cycles allowed in REQ+WAIT before bus error; 0 disables timeout (counter width $clog2(TIMEOUT+1)).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  execute stage presents a load/store
req_ready_o  out  1  LSU idle and can accept; equals (state==IDLE)
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr_i  in  32  effective address, from alu_result_o (ALU_OP_ADD)
req_wdata_i  in  32  rs2 store data, right-justified
req_rd_i  in  5  load destination register
mem_req_o  out  1  memory request, held until grant
mem_gnt_i  in  1  memory accepts request this cycle
mem_we_o  out  1  write enable
mem_addr_o  out  32  word address, {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  store data replicated to the addressed lanes
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word
rsp_valid_o  out  1  one-cycle completion pulse (loads and stores)
rsp_rd_o  out  5  rd of completed load; 0 for stores
rsp_rdata_o  out  32  extended load data; 0 for stores
err_o  out  1  one-cycle error pulse; no rsp_valid_o for that access
err_cause_o  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; held until next error

Behaviour:
- Reset: state IDLE, timeout counter 0, all mem_* and rsp_* outputs 0, err_o 0, err_cause_o 00, req_ready_o 1.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: on req_valid_i&&req_ready_o, latch the request.
  - Illegal funct3 (stores 011-111; loads 011, 110, 111) -> ERR with cause 10. Illegal takes precedence over misaligned.
  - H with addr[0]=1, or W with addr[1:0]!=0 -> ERR with cause 01.
  - Otherwise -> REQ.
- REQ: mem_req_o=1 and mem_addr_o/we/be/wdata held stable. On mem_gnt_i, a store goes to DONE and a load goes to WAIT.
- WAIT: on mem_rvalid_i, capture the extended data and go to DONE. rvalid arriving in the same cycle as gnt is not allowed; it is ignored.
- DONE: rsp_valid_o=1 for one cycle, then IDLE.
- ERR: err_o=1 for one cycle, then IDLE. No memory access is issued.
- Latency:
  - Store with gnt in the first REQ cycle: rsp_valid_o 2 cycles after accept.
  - Load with gnt in the first REQ cycle and rvalid the next cycle: rsp_valid_o 3 cycles after accept.
  - Error: err_o 1 cycle after accept.
- Byte enables: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111.
- Write data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- Load extract: select byte/half at addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout: the counter increments each cycle in REQ/WAIT and clears on leaving them. Reaching TIMEOUT goes to ERR with cause 11 and drops mem_req_o. Late rvalid/gnt seen in IDLE is ignored.
- req_valid_i while not ready is ignored; upstream holds it (stall).
- Reset mid-transaction forces IDLE immediately; no rsp/err for the aborted access.

Decomposition:
- Add to riscv_defs.v: funct3 defines LSU_B/H/W/BU/HU, err cause codes, FSM state encodings.
- One combinational sub-module, lsu_align: addr[1:0]+funct3 -> be, wdata replicate, rdata extract/extend. It is shared by the store and load paths; the FSM stays in lsu.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt first cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF, we 1; rsp_valid 2 cycles after accept, rsp_rd 0.
- SB addr 0x103, wdata 0x000000A5 -> be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x100.
- LB addr 0x202 with rdata 0x1280FF34 -> rsp_rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202 -> 0x00001280. rsp_rd equals req_rd.
- LW addr 0x101 -> err_o pulse 1 cycle after accept, err_cause 01, mem_req never asserted. Load funct3 110 -> err_cause 10.
- Load with gnt held low 3 cycles, then rvalid delayed 2 cycles -> mem_req/addr stable throughout, single rsp_valid. With TIMEOUT=4 and no gnt -> err_cause 11 after 4 REQ cycles, then req_ready 1.
- rst_ni low while in WAIT -> all outputs 0 immediately; a subsequent stray rvalid produces no rsp_valid.
